// File: rtl/evm_pkg.sv
// Shared definitions for the ballot datapath: tally width, saturation value
// and the vote controller state encoding.
package evm_pkg;

    localparam int unsigned TALLY_W = 4;
    localparam logic [TALLY_W-1:0] TALLY_MAX = 4'd15;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] ADD    = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = IDLE,
        StArmed  = ARMED,
        StAdd    = ADD,
        StCommit = COMMIT
    } state_e;

endpackage

// File: rtl/adder_4bit.sv
// Plain 4-bit ripple adder with carry out; the shared increment datapath.
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/vote_tally_ctrl.sv
// Ballot sequencing controller: arms on an officer pulse, accepts one one-hot vote,
// increments the chosen tally through a shared adder and saturates at TALLY_MAX.
module vote_tally_ctrl
    import evm_pkg::*;
#(
    parameter int unsigned N_CAND  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ballot_en,
    input  logic [N_CAND-1:0]         vote_req,
    input  logic                      clear,
    input  logic [$clog2(N_CAND)-1:0] tally_sel,
    output logic [TALLY_W-1:0]        tally_out,
    output logic                      busy,
    output logic                      vote_ack,
    output logic [$clog2(N_CAND)-1:0] ack_id,
    output logic                      invalid,
    output logic                      timeout,
    output logic [N_CAND-1:0]         overflow
);

    localparam int unsigned SEL_W = $clog2(N_CAND);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ack_q, ack_d;
    logic [SEL_W-1:0]   ack_id_q, ack_id_d;
    logic               invalid_q, invalid_d;
    logic               timeout_q, timeout_d;

    logic [TALLY_W-1:0] tally_q [N_CAND];
    logic [N_CAND-1:0]  overflow_q;
    logic [TALLY_W-1:0] sum_q;
    logic               carry_q;

    logic [TALLY_W-1:0] add_a, add_b, add_sum;
    logic               add_carry;
    logic               add_en, clear_en, commit_en;

    logic [3:0]         req_cnt;
    logic [SEL_W-1:0]   req_idx;

    // Button bank decode: population count plus index of the (last) pressed button.
    always_comb begin
        req_cnt = '0;
        req_idx = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (vote_req[i]) begin
                req_cnt = req_cnt + 4'd1;
                req_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        ack_id_d  = ack_id_q;
        invalid_d = 1'b0;
        timeout_d = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_en    = 1'b0;
        clear_en  = 1'b0;
        commit_en = 1'b0;

        unique case (state_q)
            StIdle: begin
                clear_en = clear;
                if (ballot_en) begin
                    state_d = StArmed;
                    cnt_d   = CNT_W'(TIMEOUT);
                end
            end
            StArmed: begin
                clear_en = clear;
                if (req_cnt == 4'd1) begin
                    sel_d   = req_idx;
                    state_d = StAdd;
                end else if (req_cnt > 4'd1) begin
                    // Rejected multi-press keeps the countdown where it was.
                    invalid_d = 1'b1;
                end else if (cnt_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StAdd: begin
                add_a   = tally_q[sel_q];
                add_b   = TALLY_W'(1);
                add_en  = 1'b1;
                state_d = StCommit;
            end
            StCommit: begin
                commit_en = 1'b1;
                ack_d     = 1'b1;
                ack_id_d  = sel_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    adder_4bit u_adder (
        .a         (add_a),
        .b         (add_b),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            cnt_q     <= CNT_W'(TIMEOUT);
            ack_q     <= 1'b0;
            ack_id_q  <= '0;
            invalid_q <= 1'b0;
            timeout_q <= 1'b0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            ack_id_q  <= ack_id_d;
            invalid_q <= invalid_d;
            timeout_q <= timeout_d;
            if (add_en) begin
                sum_q   <= add_sum;
                carry_q <= add_carry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CAND; i++) begin
                tally_q[i] <= '0;
            end
            overflow_q <= '0;
        end else if (clear_en) begin
            for (int i = 0; i < N_CAND; i++) begin
                tally_q[i] <= '0;
            end
            overflow_q <= '0;
        end else if (commit_en) begin
            // A carry means the tally was already at TALLY_MAX: hold it and flag.
            if (carry_q) begin
                tally_q[sel_q]    <= TALLY_MAX;
                overflow_q[sel_q] <= 1'b1;
            end else begin
                tally_q[sel_q] <= sum_q;
            end
        end
    end

    always_comb begin
        tally_out = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (tally_sel == SEL_W'(i)) begin
                tally_out = tally_q[i];
            end
        end
    end

    assign busy     = (state_q != StIdle);
    assign vote_ack = ack_q;
    assign ack_id   = ack_id_q;
    assign invalid  = invalid_q;
    assign timeout  = timeout_q;
    assign overflow = overflow_q;

endmodule
